// File: rtl/vec_alu_pkg.sv
// Shared types for the time-multiplexed vector ALU: opcodes, FSM states and
// a counter-width helper.
package vec_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRL  = 3'b110,
    OP_SADD = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A counter with a single value still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational ALU lane: computes a single N-bit element result plus its
// carry and zero flags; a disabled (masked) lane passes operand a through.
module vec_lane_alu
  import vec_alu_pkg::*;
#(
  parameter int N = 20
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  op_t          op,
  input  logic         en,
  output logic [N-1:0] y,
  output logic         carry,
  output logic         zero
);

  localparam int            SW    = $clog2(N);
  localparam logic [SW:0]   N_LIM = (SW+1)'(N);

  logic [N:0]    sum;
  logic [N:0]    diff;
  logic [SW-1:0] shamt;
  logic          sh_ok;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SW-1:0];
  assign sh_ok = ({1'b0, shamt} < N_LIM);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        y     = sum[N-1:0];
        carry = sum[N];
      end
      OP_SUB: begin
        y     = diff[N-1:0];
        carry = ~diff[N];                 // carry means "no borrow"
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = sh_ok ? (a << shamt) : '0;
      OP_SRL:  y = sh_ok ? (a >> shamt) : '0;
      OP_SADD: begin
        y     = sum[N] ? '1 : sum[N-1:0];
        carry = sum[N];
      end
      default: begin
        y     = '0;
        carry = 1'b0;
      end
    endcase
    if (!en) begin
      y     = a;
      carry = 1'b0;
    end
  end

  assign zero = (y == '0);

endmodule

// File: rtl/vector_alu_seq.sv
// Time-multiplexed vector ALU: V elements are processed by L lanes over V/L
// passes between a valid/ready operand port and a valid/ready result port.
module vector_alu_seq
  import vec_alu_pkg::*;
#(
  parameter int N = 20,
  parameter int V = 8,
  parameter int L = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [V-1:0][N-1:0] A,
  input  logic [V-1:0][N-1:0] B,
  input  logic [2:0]          Operation,
  input  logic [V-1:0]        Mask,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [V-1:0][N-1:0] Result,
  output logic [V-1:0]        Zero,
  output logic                Carry
);

  localparam int P  = V / L;
  localparam int PW = cnt_width(P);

  generate
    if ((V % L) != 0 || N < 2) begin : g_param_check
      $error("vector_alu_seq: V must be a multiple of L and N must be >= 2");
    end
  endgenerate

  state_t              state, state_nxt;
  logic [PW-1:0]       pass_cnt;
  logic [V-1:0][N-1:0] a_q, b_q;
  op_t                 op_q;
  logic [V-1:0]        mask_q;
  logic                accept;
  logic                last_pass;

  logic [L-1:0][N-1:0] lane_a, lane_b, lane_y;
  logic [L-1:0]        lane_en, lane_c, lane_z;

  assign last_pass = (pass_cnt == PW'(P - 1));
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_pass) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------- operand slice for this pass
  always_comb begin
    lane_a  = '0;
    lane_b  = '0;
    lane_en = '0;
    for (int p = 0; p < P; p++) begin
      if (pass_cnt == PW'(p)) begin
        for (int k = 0; k < L; k++) begin
          lane_a[k]  = a_q[p*L + k];
          lane_b[k]  = b_q[p*L + k];
          lane_en[k] = mask_q[p*L + k];
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < L; k++) begin : g_lane
      vec_lane_alu #(.N(N)) u_lane (
        .a     (lane_a[k]),
        .b     (lane_b[k]),
        .op    (op_q),
        .en    (lane_en[k]),
        .y     (lane_y[k]),
        .carry (lane_c[k]),
        .zero  (lane_z[k])
      );
    end
  endgenerate

  // ------------------------------- capture, pass counter and write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand registers are ordinary flops, not a RAM, so they
      // are cleared on reset along with the result so an aborted vector
      // leaves nothing behind.
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      mask_q   <= '0;
      pass_cnt <= '0;
      Result   <= '0;
      Zero     <= '0;
      Carry    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= A;
            b_q      <= B;
            op_q     <= op_t'(Operation);
            mask_q   <= Mask;
            pass_cnt <= '0;
            Zero     <= '0;
            Carry    <= 1'b0;
          end
        end
        BUSY: begin
          for (int i = 0; i < V; i++) begin
            if (pass_cnt == PW'(i / L)) begin
              Result[i] <= lane_y[i % L];
              Zero[i]   <= lane_z[i % L];
            end
          end
          Carry    <= Carry | (|lane_c);
          pass_cnt <= last_pass ? '0 : pass_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu_seq.sv
// Bench for vector_alu_seq: directed vector table, hand-written handshake and
// reset sequences, and random vectors against an arithmetic reference model.
module tb_vector_alu_seq;

  localparam int N  = 20;
  localparam int V  = 8;
  localparam int L  = 2;
  localparam int P  = V / L;
  localparam longint unsigned MOD = 64'd1 << N;
  localparam longint unsigned SHM = 64'd1 << $clog2(N);

  typedef logic [V-1:0][N-1:0] vec_t;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [V-1:0] mask;
    vec_t         a;
    vec_t         b;
    vec_t         r;
    logic [V-1:0] z;
    logic         c;
  } tv_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_valid8 = 1'b0, out_ready8 = 1'b0;
  vec_t         A, B;
  logic [2:0]   Operation;
  logic [V-1:0] Mask;

  logic         in_ready, out_valid, Carry;
  vec_t         Result;
  logic [V-1:0] Zero;
  logic         in_ready8, out_valid8, carry8;
  vec_t         result8;
  logic [V-1:0] zero8;

  int n_cmp  = 0;
  int n_fail = 0;

  vector_alu_seq #(.N(N), .V(V), .L(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Operation(Operation), .Mask(Mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .Carry(Carry)
  );

  vector_alu_seq #(.N(N), .V(V), .L(V)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A), .B(B), .Operation(Operation), .Mask(Mask),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .Result(result8), .Zero(zero8), .Carry(carry8)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Element-wise arithmetic model of the operation set.
  function automatic void model(input logic [2:0] op, input logic [V-1:0] m,
                                input vec_t a, input vec_t b,
                                output vec_t r, output logic [V-1:0] z, output logic c);
    longint unsigned x, y, s, res;
    int sh;
    c = 1'b0;
    for (int i = 0; i < V; i++) begin
      x   = 64'(a[i]);
      y   = 64'(b[i]);
      sh  = int'(y % SHM);
      res = x;
      if (m[i]) begin
        case (op)
          3'd0: begin s = x + y; res = s % MOD; if (s >= MOD) c = 1'b1; end
          3'd1: begin res = (x + MOD - y) % MOD; if (x >= y) c = 1'b1; end
          3'd2: res = x & y;
          3'd3: res = x | y;
          3'd4: res = x ^ y;
          3'd5: res = (sh >= N) ? 0 : ((x << sh) % MOD);
          3'd6: res = (sh >= N) ? 0 : (x >> sh);
          default: begin
            s = x + y;
            if (s > MOD - 1) begin res = MOD - 1; c = 1'b1; end
            else res = s;
          end
        endcase
      end
      r[i] = res[N-1:0];
      z[i] = (res == 0);
    end
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return N'($urandom_range(0, 31));
      default: return N'($urandom);
    endcase
  endfunction

  task automatic send(input logic [2:0] op, input logic [V-1:0] m, input vec_t a, input vec_t b);
    int w = 0;
    @(negedge clk);
    Operation = op; Mask = m; A = a; B = b; in_valid = 1'b1;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    check("in_ready_before_accept", 256'(in_ready), 256'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge (cycle 1).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_out(input string nm, input vec_t r, input logic [V-1:0] z, input logic c);
    check({nm, "_result"}, 256'(Result), 256'(r));
    check({nm, "_zero"},   256'(Zero),   256'(z));
    check({nm, "_carry"},  256'(Carry),  256'(c));
  endtask

  tv_t          tbl[8];
  vec_t         ea, eb, er, er2, a2, b2;
  logic [V-1:0] ez, ez2, em;
  logic [2:0]   eo;
  logic         ec, ec2;
  int           cyc;

  initial begin
    Operation = '0; Mask = '0; A = '0; B = '0;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_in_ready",  256'(in_ready),  256'(0));
    check("rst_result",    256'(Result),    256'(0));
    check("rst_zero",      256'(Zero),      256'(0));
    check("rst_carry",     256'(Carry),     256'(0));
    check("rst_in_ready8", 256'(in_ready8), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 256'(in_ready), 256'(1));

    // ---------------- directed table
    for (int t = 0; t < 8; t++) begin
      tbl[t].a = '0; tbl[t].b = '0; tbl[t].r = '0;
      tbl[t].z = '0; tbl[t].c = 1'b0; tbl[t].mask = '1;
    end
    tbl[0].name = "add";  tbl[0].op = 3'd0;
    for (int i = 0; i < V; i++) begin
      tbl[0].a[i] = N'(i + 1); tbl[0].b[i] = N'(10); tbl[0].r[i] = N'(i + 11);
    end
    tbl[1].name = "sadd_sat"; tbl[1].op = 3'd7;
    tbl[1].a[3] = 20'hFFFFF; tbl[1].b[3] = 20'h1; tbl[1].r[3] = 20'hFFFFF;
    tbl[1].z = 8'hF7; tbl[1].c = 1'b1;
    tbl[2].name = "sub_mask"; tbl[2].op = 3'd1; tbl[2].mask = 8'h0F;
    for (int i = 0; i < V; i++) begin
      tbl[2].a[i] = 20'd5; tbl[2].b[i] = 20'd5; tbl[2].r[i] = (i < 4) ? 20'd0 : 20'd5;
    end
    tbl[2].z = 8'h0F; tbl[2].c = 1'b1;
    tbl[3].name = "sll"; tbl[3].op = 3'd5;
    for (int i = 0; i < V; i++) begin
      tbl[3].a[i] = 20'd1;
      tbl[3].b[i] = (i % 2 == 0) ? 20'd19 : 20'd20;
      tbl[3].r[i] = (i % 2 == 0) ? 20'h80000 : 20'h0;
    end
    tbl[3].z = 8'hAA;
    tbl[4].name = "srl"; tbl[4].op = 3'd6;
    for (int i = 0; i < V; i++) begin
      tbl[4].a[i] = 20'h80000;
      tbl[4].b[i] = (i % 2 == 0) ? 20'd19 : 20'd35;  // 35 -> amount 3
      tbl[4].r[i] = (i % 2 == 0) ? 20'h1 : 20'h10000;
    end
    tbl[5].name = "all_masked"; tbl[5].op = 3'd0; tbl[5].mask = 8'h00;
    for (int i = 0; i < V; i++) begin
      tbl[5].a[i] = N'(i * 3); tbl[5].b[i] = 20'hFFFFF; tbl[5].r[i] = N'(i * 3);
    end
    tbl[5].z = 8'h01;
    tbl[6].name = "and"; tbl[6].op = 3'd2;
    for (int i = 0; i < V; i++) begin
      tbl[6].a[i] = 20'hF0F0F; tbl[6].b[i] = 20'h0FF0F; tbl[6].r[i] = 20'h00F0F;
    end
    tbl[7].name = "sub_borrow"; tbl[7].op = 3'd1;
    for (int i = 0; i < V; i++) begin
      tbl[7].a[i] = 20'd3; tbl[7].b[i] = 20'd5; tbl[7].r[i] = 20'hFFFFE;
    end

    for (int t = 0; t < 8; t++) begin
      send(tbl[t].op, tbl[t].mask, tbl[t].a, tbl[t].b);
      wait_done(cyc);
      check({tbl[t].name, "_latency"}, 256'(cyc), 256'(P + 1));
      check_out(tbl[t].name, tbl[t].r, tbl[t].z, tbl[t].c);
      release_out();
      check({tbl[t].name, "_valid_drop"}, 256'(out_valid), 256'(0));
    end

    // ---------------- back-pressure with a second vector waiting
    for (int i = 0; i < V; i++) begin ea[i] = pick(); eb[i] = pick(); a2[i] = pick(); b2[i] = pick(); end
    model(3'd0, '1, ea, eb, er, ez, ec);
    model(3'd7, 8'h5A, a2, b2, er2, ez2, ec2);
    send(3'd0, '1, ea, eb);
    wait_done(cyc);
    check("bp_latency", 256'(cyc), 256'(P + 1));
    Operation = 3'd7; Mask = 8'h5A; A = a2; B = b2; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_hold_valid",  256'(out_valid), 256'(1));
      check("bp_hold_ready",  256'(in_ready),  256'(0));
      check("bp_hold_result", 256'(Result),    256'(er));
    end
    check_out("bp_first", er, ez, ec);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_after_hs", 256'(out_valid), 256'(0));
    check("bp_ready_after_hs", 256'(in_ready),  256'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_taken", 256'(in_ready), 256'(0));
    wait_done(cyc);
    check("bp_second_latency", 256'(cyc), 256'(P + 1));
    check_out("bp_second", er2, ez2, ec2);
    release_out();

    // ---------------- reset in the middle of BUSY (pass 2)
    for (int i = 0; i < V; i++) begin ea[i] = pick(); eb[i] = pick(); end
    send(3'd4, '1, ea, eb);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 256'(out_valid), 256'(0));
    check("midrst_result",    256'(Result),    256'(0));
    check("midrst_zero",      256'(Zero),      256'(0));
    check("midrst_carry",     256'(Carry),     256'(0));
    check("midrst_in_ready",  256'(in_ready),  256'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (P + 3) @(negedge clk);
    check("midrst_no_partial", 256'(out_valid), 256'(0));
    check("midrst_idle_ready", 256'(in_ready),  256'(1));
    for (int i = 0; i < V; i++) begin ea[i] = pick(); eb[i] = pick(); end
    model(3'd0, 8'hC3, ea, eb, er, ez, ec);
    send(3'd0, 8'hC3, ea, eb);
    wait_done(cyc);
    check("postrst_latency", 256'(cyc), 256'(P + 1));
    check_out("postrst", er, ez, ec);
    release_out();

    // ---------------- L == V instance: single pass, latency 2
    for (int i = 0; i < V; i++) begin ea[i] = pick(); eb[i] = pick(); end
    model(3'd1, 8'hFF, ea, eb, er, ez, ec);
    @(negedge clk);
    Operation = 3'd1; Mask = 8'hFF; A = ea; B = eb; in_valid8 = 1'b1;
    check("l8_in_ready", 256'(in_ready8), 256'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    cyc = 1;
    while (!out_valid8 && cyc < 20) begin @(negedge clk); cyc++; end
    check("l8_latency", 256'(cyc),     256'(2));
    check("l8_result",  256'(result8), 256'(er));
    check("l8_zero",    256'(zero8),   256'(ez));
    check("l8_carry",   256'(carry8),  256'(ec));
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("l8_valid_drop", 256'(out_valid8), 256'(0));

    // ---------------- random vectors against the model
    for (int n = 0; n < 40; n++) begin
      eo = 3'($urandom_range(0, 7));
      em = V'($urandom);
      for (int i = 0; i < V; i++) begin ea[i] = pick(); eb[i] = pick(); end
      model(eo, em, ea, eb, er, ez, ec);
      out_ready = 1'($urandom_range(0, 1));  // early ready must not matter
      send(eo, em, ea, eb);
      wait_done(cyc);
      check("rand_latency", 256'(cyc), 256'(P + 1));
      check_out("rand", er, ez, ec);
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_alu_seq.md
Name: vector_alu_seq

Overview:
- Parametrised, time-multiplexed successor to the 8-lane combinational vector ALU.
- Processes a V-element vector of N-bit operands through L physical lanes over V/L passes.
- Adds per-element mask, saturating add, shifts, a per-element zero flag and a sticky carry flag.
- Sits between the vector register file read stage and writeback.
- Uses valid/ready handshakes on both sides, so the pipeline can stall.

Parameters:
- N, 20, element width in bits (N >= 2).
- V, 8, elements per vector.
- L, 2, physical lanes; V mod L == 0 is required (elaboration-time assertion).
- P, V/L (derived localparam, not overridable), number of passes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept a vector.
- A  in  [V-1:0][N-1:0]  operand A elements.
- B  in  [V-1:0][N-1:0]  operand B elements.
- Operation  in  3  opcode (see package).
- Mask  in  V  per-element enable; 0 = element passes A through unchanged.
- out_valid  out  1  Result is valid.
- out_ready  in  1  consumer accepts Result.
- Result  out  [V-1:0][N-1:0]  result elements.
- Zero  out  V  per-element Result == 0.
- Carry  out  1  OR of carry-out over unmasked elements (ADD/SUB/SADD only).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; Result=0; Zero=0; Carry=0; out_valid=0; in_ready=0 while rst asserted.
  - Internal pass counter and captured operands are cleared.
  - A reset mid-operation aborts the vector; no partial output is produced.
- Opcodes:
  - 000 ADD: A+B mod 2^N.
  - 001 SUB: A-B mod 2^N; carry = no-borrow (A>=B).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: A << B[clog2(N)-1:0]; shift amounts >= N give 0.
  - 110 SRL: logical shift right, same amount rule as SLL.
  - 111 SADD: unsigned saturating add; saturates to 2^N-1 and sets carry.
- FSM IDLE:
  - in_ready=1.
  - On in_valid: capture A, B, Operation and Mask; clear pass counter, Carry and Zero; go to BUSY.
- FSM BUSY:
  - in_ready=0.
  - Each cycle, lanes 0..L-1 compute elements p*L+k.
  - Results, zero bits and carry are registered into those element slots; Carry accumulates by OR.
  - When p==P-1, go to DONE; otherwise p<=p+1.
- FSM DONE:
  - out_valid=1; Result, Zero and Carry are held stable.
  - On out_ready: out_valid drops next cycle and state returns to IDLE.
- Latency:
  - Accept edge to out_valid high is P+1 cycles (P passes plus DONE register).
  - Throughput is one vector per P+2 cycles.
  - No accept occurs in the same cycle as out_ready (no bypass).
- Masking:
  - A masked element yields Result=A[i] and Zero=(A[i]==0).
  - A masked element does not contribute to Carry.
- Mask==0 (all masked): the vector still takes P passes, then Result=A.
- Degenerate case L==V: P=1; BUSY lasts 1 cycle.
- in_valid in BUSY/DONE: ignored; the upstream holds the vector because in_ready=0.
- out_ready held high before DONE: has no effect until DONE.

Decomposition:
- Package vec_alu_pkg:
  - typedef enum logic [2:0] op_t, with the codes above.
  - typedef enum logic [1:0] state_t {IDLE, BUSY, DONE}.
- Sub-module vec_lane_alu #(N):
  - Combinational single lane; inputs a, b, op, en; outputs y, carry, zero.
  - Instantiated L times in a generate loop.
  - The top level holds the FSM, pass counter, operand registers and element write-back demux.

Test Plan (N=20, V=8, L=2, P=4 unless noted):
- ADD, all lanes: A[i]=i+1, B[i]=10, Mask=FF -> 5 cycles after accept, out_valid=1, Result[i]=i+11, Zero=00, Carry=0.
- SADD overflow: A[3]=FFFFF, B[3]=1, others 0+0, Mask=FF -> Result[3]=FFFFF, Result[others]=0, Zero=F7, Carry=1.
- Masking with SUB: A[i]=5, B[i]=5, Mask=0F -> Result[3:0]=0, Result[7:4]=5, Zero=0F, Carry=1 (no borrow).
- Shifts: SLL with A=1, B=19 -> 80000; SLL with B=20 -> 0; SRL with A=80000, B=19 -> 1.
- Back-pressure: out_ready=0 for 6 cycles in DONE -> Result stable, in_ready=0, a second in_valid is not accepted; it is accepted the cycle after the handshake.
- Reset mid-BUSY (pass 2): rst pulse -> out_valid=0, Result=0; the next vector completes normally. Separately, with L=8: latency is 2 cycles.
